seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Player-side checker for the Genius game.
- Drives an address into the sequence ROM and reads back the expected one-hot colour.
- Accepts the player's button presses and compares each press against that expected colour.
- Reports round success or failure to the game controller. It is the consumer of the sequence ROM interface.

Parameters:
SIZE, 4, width of ROM address/level and of colour bus (colour bus fixed one-hot, SIZE bits)
TIMEOUT_CYC, 1000, clock cycles allowed without a press before failure (only with SEQ_CHK_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: begin checking a round; ignored unless ocupado=0
nivel  input  SIZE  index of last step of round (round length = nivel+1)
botoes  input  SIZE  player buttons, active-high, already synchronised to clk
endereco  output  SIZE  address to sequence ROM
esperado  input  SIZE  ROM data for endereco (combinational, valid same cycle)
passo  output  SIZE  number of steps already matched in current round
ocupado  output  1  high while a round is being checked
acerto  output  1  one-cycle pulse: whole round matched
erro  output  1  one-cycle pulse: wrong, multiple or late press

Behaviour:
- Reset (rst_n=0, async):
  - State IDLE.
  - endereco=0, passo=0, ocupado=0, acerto=0, erro=0, timer=0, captured press=0.
- All outputs are registered.
- States: IDLE, ESPERA, SOLTA, ACERTO, ERRO.
- IDLE:
  - ocupado=0.
  - On start=1: endereco<=0, passo<=0, timer<=0, latch nivel internally, go ESPERA.
- ESPERA (waiting for a press):
  - botoes==0: timer increments.
  - botoes!=0 and exactly one bit set: capture botoes, go SOLTA.
  - botoes has more than one bit set: go ERRO.
- SOLTA (waiting for release):
  - Stays while botoes!=0.
  - On botoes==0, compare captured press with esperado:
    - mismatch -> ERRO;
    - match and endereco==latched nivel -> ACERTO, passo<=passo+1;
    - match otherwise -> endereco<=endereco+1, passo<=passo+1, timer<=0, go ESPERA.
  - Changes to botoes while held (e.g. a second button added) are ignored; only the first captured press counts.
- ACERTO: acerto=1 for exactly this cycle, then IDLE.
- ERRO: erro=1 for exactly this cycle, then IDLE.
- Latency:
  - Release sampled in SOLTA at edge N -> acerto/erro high from edge N+1 for one cycle.
  - ocupado falls at edge N+2.
- ocupado=1 in ESPERA, SOLTA, ACERTO, ERRO.
- start while ocupado=1: ignored, nivel not re-latched.
- nivel changes mid-round: no effect (latched value used).
- nivel=0: round of one step.
- nivel=2^SIZE-1: endereco reaches all-ones then ACERTO; no wrap.
- passo holds its final value in IDLE until the next start.
- endereco holds its last value in IDLE.
- rst_n asserted mid-round: immediate return to reset values; no acerto/erro pulse.
- acerto and erro are never high in the same cycle.

Optional Feature:
- Macro SEQ_CHK_TIMEOUT_EN.
- Defined:
  - In ESPERA, if timer reaches TIMEOUT_CYC-1 with botoes==0, go ERRO; erro pulses TIMEOUT_CYC+1 cycles after entering ESPERA.
  - The timer is a counter of ceil(log2(TIMEOUT_CYC)) bits, saturating.
  - The timer does not run in SOLTA.
- Undefined:
  - No timer logic is present; ESPERA waits indefinitely.
  - TIMEOUT_CYC is unused.

Test Plan:
- Reset: hold rst_n=0 mid-round (state SOLTA) -> endereco=0, passo=0, ocupado=0, acerto=erro=0 asynchronously; no pulse after release.
- Correct round: ROM model addr0=0001, addr1=0100, addr2=0010, nivel=2; press/release 0001, 0100, 0010 -> endereco steps 0,1,2; passo ends 3; single acerto pulse one cycle after the last release; erro never high.
- Wrong colour: same ROM, nivel=2; press 0001, then 0010 -> erro pulse after second release; passo=1; endereco=1.
- Multiple buttons: botoes=0101 in ESPERA -> erro next cycle; a start during the erro cycle is ignored.
- Single-step and held button: nivel=0, hold 0001 for 50 cycles, then add 0100 before release -> no action until botoes==0, then acerto (captured 0001 matches).
- Timeout (macro defined, TIMEOUT_CYC=8): start, no press -> erro exactly 9 cycles after entering ESPERA; with the macro undefined, no erro after 10000 idle cycles.

Source files
------------

// File: rtl/seq_checker.sv
// seq_checker: player-side checker for the Genius game.
// Walks the sequence ROM address by address. Each button press is checked
// against the expected one-hot colour, and the result is reported as an
// acerto or erro pulse.
// Optional feature: define SEQ_CHK_TIMEOUT_EN to fail a round when no press
// arrives within TIMEOUT_CYC cycles.
module seq_checker #(
   parameter int SIZE        = 4,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] nivel,
   input  logic [SIZE-1:0] botoes,
   output logic [SIZE-1:0] endereco,
   input  logic [SIZE-1:0] esperado,
   output logic [SIZE-1:0] passo,
   output logic            ocupado,
   output logic            acerto,
   output logic            erro
);

   typedef enum logic [2:0] {IDLE, ESPERA, SOLTA, ACERTO, ERRO} state_t;

   state_t          state, state_n;
   logic [SIZE-1:0] end_n, passo_n;
   logic [SIZE-1:0] cap, cap_n;     // first press captured in ESPERA
   logic [SIZE-1:0] niv, niv_n;     // nivel latched at start
   logic            none, one_hot, tmo;

   assign none    = (botoes == '0);
   assign one_hot = !none && ((botoes & (botoes - SIZE'(1))) == '0);

`ifdef SEQ_CHK_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] timer, timer_n;

   assign tmo = (timer == TW'(TIMEOUT_CYC - 1));

   // Idle-wait counter: runs only in ESPERA with no press and saturates.
   // It is cleared outside ESPERA, so every entry into ESPERA starts from 0.
   always_comb begin
      timer_n = '0;
      if (state == ESPERA) begin
         timer_n = timer;
         if (none && timer != '1) timer_n = timer + TW'(1);
      end
   end

   // Timer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer <= '0;
      else        timer <= timer_n;
   end
`else
   assign tmo = 1'b0;
   wire unused_timeout = (TIMEOUT_CYC != 0);
`endif

   // Next-state and datapath logic.
   always_comb begin
      state_n = state;
      end_n   = endereco;
      passo_n = passo;
      cap_n   = cap;
      niv_n   = niv;
      case (state)
         IDLE: begin
            // ocupado lags the state by one cycle. A start arriving in the
            // cycle after a pulse is still refused.
            if (start && !ocupado) begin
               state_n = ESPERA;
               end_n   = '0;
               passo_n = '0;
               niv_n   = nivel;
            end
         end
         ESPERA: begin
            if (none) begin
               if (tmo) state_n = ERRO;
            end else if (one_hot) begin
               cap_n   = botoes;
               state_n = SOLTA;
            end else begin
               state_n = ERRO;
            end
         end
         SOLTA: begin
            if (none) begin
               if (cap != esperado) begin
                  state_n = ERRO;
               end else if (endereco == niv) begin
                  state_n = ACERTO;
                  passo_n = passo + SIZE'(1);
               end else begin
                  state_n = ESPERA;
                  end_n   = endereco + SIZE'(1);
                  passo_n = passo + SIZE'(1);
               end
            end
         end
         ACERTO:  state_n = IDLE;
         ERRO:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         endereco <= '0;
         passo    <= '0;
         cap      <= '0;
         niv      <= '0;
      end else begin
         state    <= state_n;
         endereco <= end_n;
         passo    <= passo_n;
         cap      <= cap_n;
         niv      <= niv_n;
      end
   end

   // Registered status outputs. Each one trails the state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ocupado <= 1'b0;
         acerto  <= 1'b0;
         erro    <= 1'b0;
      end else begin
         ocupado <= (state != IDLE);
         acerto  <= (state == ACERTO);
         erro    <= (state == ERRO);
      end
   end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a small combinational sequence-ROM model.
module tb_seq_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] nivel = '0;
   logic [3:0] botoes = '0;
   logic [3:0] endereco, esperado, passo;
   logic       ocupado, acerto, erro;

   int errors = 0;
   int checks = 0;

   seq_checker #(.SIZE(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .nivel(nivel),
      .botoes(botoes), .endereco(endereco), .esperado(esperado),
      .passo(passo), .ocupado(ocupado), .acerto(acerto), .erro(erro)
   );

   always #5 clk = ~clk;

   // ROM model: addr0=0001, addr1=0100, addr2=0010.
   always_comb begin
      case (endereco)
         4'd0:    esperado = 4'b0001;
         4'd1:    esperado = 4'b0100;
         4'd2:    esperado = 4'b0010;
         default: esperado = 4'b1000;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in ESPERA with ocupado already high.
   task automatic do_start(input logic [3:0] nv);
      start = 1'b1;
      nivel = nv;
      tick();
      start = 1'b0;
      tick();
   endtask

   // Returns just after the edge that samples the release.
   task automatic press(input logic [3:0] b);
      botoes = b;
      tick();
      botoes = 4'b0000;
      tick();
   endtask

   task automatic test_reset();
      #3;
      checks++; if ({endereco, passo, ocupado, acerto, erro} !== 11'd0) begin
         errors++; $display("FAIL reset_init: got %h %h %b%b%b want 0 0 000", endereco, passo, ocupado, acerto, erro);
      end
      rst_n = 1'b1;
      tick();
      do_start(4'd2);
      press(4'b0001);
      botoes = 4'b0100;
      tick();
      checks++; if (endereco !== 4'd1 || passo !== 4'd1) begin
         errors++; $display("FAIL pre_reset: got end=%0d passo=%0d want 1 1", endereco, passo);
      end
      #2 rst_n = 1'b0;
      #2;
      checks++; if ({endereco, passo, ocupado, acerto, erro} !== 11'd0) begin
         errors++; $display("FAIL reset_async: got %h %h %b%b%b want 0 0 000", endereco, passo, ocupado, acerto, erro);
      end
      botoes = 4'b0000;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (acerto !== 1'b0 || erro !== 1'b0 || ocupado !== 1'b0) begin
            errors++; $display("FAIL reset_nopulse: got a=%b e=%b o=%b want 000", acerto, erro, ocupado);
         end
      end
   endtask

   task automatic test_correct();
      start = 1'b1;
      nivel = 4'd2;
      tick();
      start = 1'b0;
      nivel = 4'd0;          // mid-round change must be ignored
      checks++; if (ocupado !== 1'b0) begin
         errors++; $display("FAIL ocupado_lag: got %b want 0", ocupado);
      end
      tick();
      checks++; if (ocupado !== 1'b1 || endereco !== 4'd0) begin
         errors++; $display("FAIL round_begin: got o=%b end=%0d want 1 0", ocupado, endereco);
      end
      press(4'b0001);
      checks++; if (endereco !== 4'd1 || passo !== 4'd1) begin
         errors++; $display("FAIL step1: got end=%0d passo=%0d want 1 1", endereco, passo);
      end
      press(4'b0100);
      checks++; if (endereco !== 4'd2 || passo !== 4'd2) begin
         errors++; $display("FAIL step2: got end=%0d passo=%0d want 2 2", endereco, passo);
      end
      press(4'b0010);
      checks++; if (acerto !== 1'b0 || passo !== 4'd3 || endereco !== 4'd2) begin
         errors++; $display("FAIL step3: got a=%b passo=%0d end=%0d want 0 3 2", acerto, passo, endereco);
      end
      tick();
      checks++; if (acerto !== 1'b1 || erro !== 1'b0 || ocupado !== 1'b1) begin
         errors++; $display("FAIL acerto_pulse: got a=%b e=%b o=%b want 101", acerto, erro, ocupado);
      end
      tick();
      checks++; if (acerto !== 1'b0 || ocupado !== 1'b0 || passo !== 4'd3 || endereco !== 4'd2) begin
         errors++; $display("FAIL round_end: got a=%b o=%b passo=%0d end=%0d want 0 0 3 2", acerto, ocupado, passo, endereco);
      end
   endtask

   task automatic test_wrong();
      do_start(4'd2);
      press(4'b0001);
      press(4'b0010);
      checks++; if (erro !== 1'b0) begin
         errors++; $display("FAIL wrong_lat: got erro=%b want 0", erro);
      end
      tick();
      checks++; if (erro !== 1'b1 || acerto !== 1'b0 || passo !== 4'd1 || endereco !== 4'd1) begin
         errors++; $display("FAIL wrong_pulse: got e=%b a=%b passo=%0d end=%0d want 1 0 1 1", erro, acerto, passo, endereco);
      end
      tick();
      checks++; if (erro !== 1'b0 || ocupado !== 1'b0) begin
         errors++; $display("FAIL wrong_end: got e=%b o=%b want 0 0", erro, ocupado);
      end
   endtask

   task automatic test_multi();
      do_start(4'd2);
      botoes = 4'b0101;
      tick();
      botoes = 4'b0000;
      checks++; if (erro !== 1'b0) begin
         errors++; $display("FAIL multi_lat: got erro=%b want 0", erro);
      end
      tick();
      checks++; if (erro !== 1'b1) begin
         errors++; $display("FAIL multi_pulse: got erro=%b want 1", erro);
      end
      start = 1'b1;
      nivel = 4'd1;
      tick();
      start = 1'b0;
      checks++; if (erro !== 1'b0 || ocupado !== 1'b0) begin
         errors++; $display("FAIL multi_end: got e=%b o=%b want 0 0", erro, ocupado);
      end
      tick();
      checks++; if (ocupado !== 1'b0) begin
         errors++; $display("FAIL start_ignored: got ocupado=%b want 0", ocupado);
      end
   endtask

   task automatic test_hold();
      logic bad;
      bad = 1'b0;
      do_start(4'd0);
      botoes = 4'b0001;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (acerto !== 1'b0 || erro !== 1'b0 || ocupado !== 1'b1) bad = 1'b1;
      end
      botoes = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (acerto !== 1'b0 || erro !== 1'b0 || ocupado !== 1'b1) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin
         errors++; $display("FAIL hold_quiet: got activity=%b want 0", bad);
      end
      botoes = 4'b0000;
      tick();
      tick();
      checks++; if (acerto !== 1'b1 || erro !== 1'b0 || passo !== 4'd1 || endereco !== 4'd0) begin
         errors++; $display("FAIL hold_acerto: got a=%b e=%b passo=%0d end=%0d want 1 0 1 0", acerto, erro, passo, endereco);
      end
      tick();
   endtask

   task automatic test_timeout();
`ifdef SEQ_CHK_TIMEOUT_EN
      start = 1'b1;
      nivel = 4'd2;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         checks++; if (erro !== (k == 9)) begin
            errors++; $display("FAIL timeout_k%0d: got erro=%b want %b", k, erro, (k == 9));
         end
      end
      tick();
`else
      logic seen;
      seen = 1'b0;
      do_start(4'd2);
      for (int i = 0; i < 10000; i++) begin
         tick();
         if (erro !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0 || ocupado !== 1'b1) begin
         errors++; $display("FAIL no_timeout: got erro_seen=%b o=%b want 0 1", seen, ocupado);
      end
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_correct();
      test_wrong();
      test_multi();
      test_hold();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // acerto and erro must be mutually exclusive.
   always @(negedge clk) begin
      if (acerto && erro) begin
         errors++;
         $display("FAIL exclusive: got acerto=1 erro=1 want not both");
      end
   end

endmodule
